bcd_counter_hex: RTL and testbench

- Parametrised multi-digit BCD counter with registered seven-segment outputs. Successor to the fixed two-digit board counter.
- Adds digit-count generality, an internal tick prescaler, up/down mode, parallel load, enable and a wrap pulse.
- Sits between board I/O (KEY/SW) and the HEX display drivers; one instance drives NUM_DIGITS adjacent HEX displays.

---
 rtl/bcd_counter_hex.sv | 124 ++++++++++++
 tb/tb_bcd_counter_hex.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_hex.sv
// Multi-digit BCD up/down counter with prescaled tick, parallel load and wrap pulse; bcd/tick/wrap update on the step edge.
// Seven-segment hex lags bcd by one clk; no backpressure, load overrides a coincident step.
module bcd_counter_hex #(
  parameter int NUM_DIGITS     = 2,
  parameter int TICK_DIV       = 50000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    wrap,
  output logic [8*NUM_DIGITS-1:0] hex
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [7:0] seg_enc(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    if (blank) s = 7'h00;
    return SEG_ACTIVE_LOW ? ~{1'b0, s} : {1'b0, s};
  endfunction

  // Leading-zero blanking walks from the top digit down; digit 0 always shows.
  function automatic logic [8*NUM_DIGITS-1:0] hex_enc(input logic [4*NUM_DIGITS-1:0] v);
    logic [8*NUM_DIGITS-1:0] h;
    logic                    allz;
    h    = '0;
    allz = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allz = allz & (v[4*i +: 4] == 4'd0);
      h[8*i +: 8] = seg_enc(v[4*i +: 4], BLANK_LZ && allz && (i != 0));
    end
    return h;
  endfunction

  localparam logic [8*NUM_DIGITS-1:0] HEX_ZERO = hex_enc('0);

  logic [PW-1:0]           pre;
  logic                    step;
  logic [4*NUM_DIGITS-1:0] bcd_step;
  logic [4*NUM_DIGITS-1:0] load_clean;
  logic                    cy;

  assign step = en && (pre == PW'(TICK_DIV - 1));

  // Ripple carry/borrow; cy surviving past the top digit is the wrap condition.
  always_comb begin
    bcd_step = bcd;
    cy       = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (up_dn) begin
          if (bcd[4*i +: 4] == 4'd9) begin
            bcd_step[4*i +: 4] = 4'd0;
          end else begin
            bcd_step[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (bcd[4*i +: 4] == 4'd0) begin
            bcd_step[4*i +: 4] = 4'd9;
          end else begin
            bcd_step[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_clean = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre  <= '0;
      bcd  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      hex  <= HEX_ZERO;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      hex  <= hex_enc(bcd);
      if (load) begin
        bcd <= load_clean;
        pre <= '0;
      end else if (en) begin
        if (step) begin
          pre  <= '0;
          bcd  <= bcd_step;
          tick <= 1'b1;
          wrap <= cy;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_hex.sv
// Directed bench: three instances (2 digits/div 4, 2 digits/div 1, 3 digits/div 1 with blanking).
module tb_bcd_counter_hex;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        a_en = 0, a_up = 0, a_load = 0;
  logic [7:0]  a_lv = '0;
  logic [7:0]  a_bcd;
  logic        a_tick, a_wrap;
  logic [15:0] a_hex;

  logic        b_en = 0, b_up = 0, b_load = 0;
  logic [7:0]  b_lv = '0;
  logic [7:0]  b_bcd;
  logic        b_tick, b_wrap;
  logic [15:0] b_hex;

  logic        c_en = 0, c_up = 0, c_load = 0;
  logic [11:0] c_lv = '0;
  logic [11:0] c_bcd;
  logic        c_tick, c_wrap;
  logic [23:0] c_hex;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_counter_hex #(.NUM_DIGITS(2), .TICK_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)) u_a (
    .clk(clk), .reset_n(reset_n), .en(a_en), .up_dn(a_up), .load(a_load), .load_val(a_lv),
    .bcd(a_bcd), .tick(a_tick), .wrap(a_wrap), .hex(a_hex));

  bcd_counter_hex #(.NUM_DIGITS(2), .TICK_DIV(1), .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)) u_b (
    .clk(clk), .reset_n(reset_n), .en(b_en), .up_dn(b_up), .load(b_load), .load_val(b_lv),
    .bcd(b_bcd), .tick(b_tick), .wrap(b_wrap), .hex(b_hex));

  bcd_counter_hex #(.NUM_DIGITS(3), .TICK_DIV(1), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)) u_c (
    .clk(clk), .reset_n(reset_n), .en(c_en), .up_dn(c_up), .load(c_load), .load_val(c_lv),
    .bcd(c_bcd), .tick(c_tick), .wrap(c_wrap), .hex(c_hex));

  task test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_bcd: got %h want 00", a_bcd); end
    n_cmp++; if (a_hex !== 16'hC0C0) begin n_bad++; $display("FAIL reset_hex: got %h want C0C0", a_hex); end
    n_cmp++; if (a_tick !== 1'b0 || a_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_tick_wrap: got %b%b want 00", a_tick, a_wrap); end
    n_cmp++; if (c_hex !== 24'hFFFFC0) begin n_bad++; $display("FAIL reset_hex_blank: got %h want FFFFC0", c_hex); end
  endtask

  task test_first_tick();
    a_en = 1'b1; a_up = 1'b1; reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_tick !== 1'b0 || a_bcd !== 8'h00) begin n_bad++; $display("FAIL early_tick: got tick %b bcd %h want 0 00", a_tick, a_bcd); end
    @(negedge clk);
    n_cmp++; if (a_tick !== 1'b1 || a_bcd !== 8'h01) begin n_bad++; $display("FAIL first_tick: got tick %b bcd %h want 1 01", a_tick, a_bcd); end
    @(negedge clk);
    n_cmp++; if (a_hex !== 16'hC0F9 || a_tick !== 1'b0) begin n_bad++; $display("FAIL first_hex: got hex %h tick %b want C0F9 0", a_hex, a_tick); end
  endtask

  task test_en_hold();
    int first;
    first = -1;
    a_load = 1'b1; a_lv = 8'h00; a_en = 1'b1; a_up = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      a_en = !(k >= 2 && k <= 4);
      @(negedge clk);
      if (a_tick === 1'b1 && first < 0) first = k;
    end
    n_cmp++; if (first !== 7) begin n_bad++; $display("FAIL en_hold_spacing: got %0d want 7", first); end
    n_cmp++; if (a_bcd !== 8'h02) begin n_bad++; $display("FAIL en_hold_bcd: got %h want 02", a_bcd); end
  endtask

  task test_load_vs_step();
    a_load = 1'b1; a_lv = 8'h00; a_en = 1'b1; a_up = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (3) @(negedge clk);
    a_load = 1'b1; a_lv = 8'h3C;
    @(negedge clk);
    n_cmp++; if (a_bcd !== 8'h30 || a_tick !== 1'b0) begin n_bad++; $display("FAIL load_wins: got bcd %h tick %b want 30 0", a_bcd, a_tick); end
    a_load = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_bcd !== 8'h30 || a_tick !== 1'b0) begin n_bad++; $display("FAIL load_pre_clear: got bcd %h tick %b want 30 0", a_bcd, a_tick); end
    @(negedge clk);
    n_cmp++; if (a_bcd !== 8'h31 || a_tick !== 1'b1) begin n_bad++; $display("FAIL after_load_step: got bcd %h tick %b want 31 1", a_bcd, a_tick); end
    a_en = 1'b0;
  endtask

  task test_wrap_up();
    b_en = 1'b1; b_up = 1'b1; b_load = 1'b1; b_lv = 8'h98;
    @(negedge clk);
    n_cmp++; if (b_bcd !== 8'h98 || b_tick !== 1'b0) begin n_bad++; $display("FAIL up_load98: got bcd %h tick %b want 98 0", b_bcd, b_tick); end
    b_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_bcd !== 8'h99 || b_tick !== 1'b1 || b_wrap !== 1'b0) begin n_bad++; $display("FAIL up_99: got bcd %h tick %b wrap %b want 99 1 0", b_bcd, b_tick, b_wrap); end
    @(negedge clk);
    n_cmp++; if (b_bcd !== 8'h00 || b_wrap !== 1'b1 || b_hex !== 16'h9090) begin n_bad++; $display("FAIL up_wrap: got bcd %h wrap %b hex %h want 00 1 9090", b_bcd, b_wrap, b_hex); end
    @(negedge clk);
    n_cmp++; if (b_bcd !== 8'h01 || b_wrap !== 1'b0 || b_tick !== 1'b1 || b_hex !== 16'hC0C0) begin n_bad++; $display("FAIL up_post_wrap: got bcd %h wrap %b tick %b hex %h want 01 0 1 C0C0", b_bcd, b_wrap, b_tick, b_hex); end
  endtask

  task test_down();
    b_up = 1'b0; b_load = 1'b1; b_lv = 8'h10;
    @(negedge clk);
    b_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_bcd !== 8'h09 || b_wrap !== 1'b0) begin n_bad++; $display("FAIL down_borrow: got bcd %h wrap %b want 09 0", b_bcd, b_wrap); end
    b_load = 1'b1; b_lv = 8'h00;
    @(negedge clk);
    b_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_bcd !== 8'h99 || b_wrap !== 1'b1) begin n_bad++; $display("FAIL down_wrap: got bcd %h wrap %b want 99 1", b_bcd, b_wrap); end
    @(negedge clk);
    n_cmp++; if (b_bcd !== 8'h98 || b_wrap !== 1'b0 || b_hex !== 16'h9090) begin n_bad++; $display("FAIL down_hex: got bcd %h wrap %b hex %h want 98 0 9090", b_bcd, b_wrap, b_hex); end
    b_en = 1'b0;
  endtask

  task test_blank();
    c_en = 1'b0; c_load = 1'b1; c_lv = 12'h005;
    @(negedge clk);
    c_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (c_hex !== 24'hFFFF92) begin n_bad++; $display("FAIL blank_005: got %h want FFFF92", c_hex); end
    c_load = 1'b1; c_lv = 12'hA5F;
    @(negedge clk);
    c_load = 1'b0;
    n_cmp++; if (c_bcd !== 12'h050) begin n_bad++; $display("FAIL load_sanitise: got %h want 050", c_bcd); end
    @(negedge clk);
    n_cmp++; if (c_hex !== 24'hFF92C0) begin n_bad++; $display("FAIL blank_050: got %h want FF92C0", c_hex); end
    c_load = 1'b1; c_lv = 12'h047;
    @(negedge clk);
    c_load = 1'b0;
    @(negedge clk);
    n_cmp++; if (c_bcd !== 12'h047 || c_hex !== 24'hFF99F8) begin n_bad++; $display("FAIL blank_047: got bcd %h hex %h want 047 FF99F8", c_bcd, c_hex); end
  endtask

  task test_reset_mid();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (c_bcd !== 12'h000 || c_hex !== 24'hFFFFC0) begin n_bad++; $display("FAIL async_reset: got bcd %h hex %h want 000 FFFFC0", c_bcd, c_hex); end
    n_cmp++; if (b_bcd !== 8'h00 || b_hex !== 16'hC0C0) begin n_bad++; $display("FAIL async_reset_b: got bcd %h hex %h want 00 C0C0", b_bcd, b_hex); end
    @(negedge clk);
    reset_n = 1'b1; c_en = 1'b1; c_up = 1'b1;
    @(negedge clk);
    n_cmp++; if (c_bcd !== 12'h001 || c_tick !== 1'b1) begin n_bad++; $display("FAIL resume_after_reset: got bcd %h tick %b want 001 1", c_bcd, c_tick); end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_en_hold();
    test_load_vs_step();
    test_wrap_up();
    test_down();
    test_blank();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
